// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU op codes, branch conditions and shifter FSM states for the EX stage
package ex_pkg;

  localparam int XLEN   = 32;
  localparam int SHAMTW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// rtl/ex_serial_shifter.sv - iterative 1-bit/cycle shifter; stalls the front end until the result is ready
module ex_serial_shifter
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SHAMTW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              start_i,
  input  logic [3:0]        alu_op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [SHAMTW-1:0] shamt_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o
);

  shift_state_e      state_q, state_d;
  logic [XLEN-1:0]   shift_q, shift_d;
  logic [SHAMTW-1:0] cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;

  function automatic logic [XLEN-1:0] shift1(logic [3:0] op, logic [XLEN-1:0] v);
    case (op)
      OP_SRL:  return {1'b0, v[XLEN-1:1]};
      OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {v[XLEN-2:0], 1'b0};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (shamt_i != '0)) begin
          stall_o = 1'b1;
          op_d    = alu_op_i;
          shift_d = shift1(alu_op_i, a_i);
          cnt_d   = shamt_i - SHAMTW'(1);
          state_d = (shamt_i == SHAMTW'(1)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        stall_o = 1'b1;
        shift_d = shift1(op_q, shift_q);
        cnt_d   = cnt_q - SHAMTW'(1);
        if (cnt_q == SHAMTW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (!hold_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush kills the shift outright, even in the cycle it would have launched.
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign result_o = shift_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU, branch comparator and serial shifter
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SHAMTW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] port_a_i,
  input  logic [XLEN-1:0] port_b_i,
  input  logic            comp_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            branch_taken_o,
  output logic            stall_o
);

  logic [SHAMTW-1:0] shamt;
  logic              sh_stall, sh_done;
  logic [XLEN-1:0]   sh_result;
  logic [XLEN-1:0]   alu_res;
  logic              cond;

  assign shamt = port_b_i[SHAMTW-1:0];

  ex_serial_shifter #(.XLEN(XLEN), .SHAMTW(SHAMTW)) u_shifter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .hold_i   (hold_i),
    .start_i  (is_shift_op(alu_op_i)),
    .alu_op_i (alu_op_i),
    .a_i      (port_a_i),
    .shamt_i  (shamt),
    .stall_o  (sh_stall),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      OP_ADD:  alu_res = port_a_i + port_b_i;
      OP_SUB:  alu_res = port_a_i - port_b_i;
      OP_AND:  alu_res = port_a_i & port_b_i;
      OP_OR:   alu_res = port_a_i | port_b_i;
      OP_XOR:  alu_res = port_a_i ^ port_b_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(port_a_i) < $signed(port_b_i)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, port_a_i < port_b_i};
      // Zero shift bypasses the FSM; nonzero shifts show nothing until DONE.
      OP_SLL, OP_SRL, OP_SRA: alu_res = (shamt == '0) ? port_a_i : '0;
      default: alu_res = '0;
    endcase
    if (sh_done) alu_res = sh_result;
  end

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond = (port_a_i == port_b_i);
      F3_BNE:  cond = (port_a_i != port_b_i);
      F3_BLT:  cond = ($signed(port_a_i) <  $signed(port_b_i));
      F3_BGE:  cond = ($signed(port_a_i) >= $signed(port_b_i));
      F3_BLTU: cond = (port_a_i <  port_b_i);
      F3_BGEU: cond = (port_a_i >= port_b_i);
      default: cond = 1'b0;
    endcase
  end

  assign alu_result_o   = rst_i ? '0 : alu_res;
  assign branch_taken_o = !rst_i && comp_i && cond;
  assign stall_o        = !rst_i && sh_stall;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - vector table, directed shift sequences and randomized checks for ex_stage
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, hold, comp, taken, stall;
  logic [3:0]  op;
  logic [31:0] a, b, res;
  logic [2:0]  f3;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .SHAMTW(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .hold_i         (hold),
    .alu_op_i       (op),
    .port_a_i       (a),
    .port_b_i       (b),
    .comp_i         (comp),
    .funct3_i       (f3),
    .alu_result_o   (res),
    .branch_taken_o (taken),
    .stall_o        (stall)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [2:0]  f3;
    logic [31:0] res;
    logic        tk;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    int     sh;
    longint sx, sy;
    sh = int'(y % 32);
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: return (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return 32'(sx >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(logic c, logic [2:0] f, logic [31:0] x, logic [31:0] y);
    longint sx, sy, ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = longint'(x);
    uy = longint'(y);
    if (!c) return 1'b0;
    case (f)
      3'b000:  return ux == uy;
      3'b001:  return ux != uy;
      3'b100:  return sx < sy;
      3'b101:  return sx >= sy;
      3'b110:  return ux < uy;
      3'b111:  return ux >= uy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(logic [3:0] o, logic [31:0] x, logic [31:0] y, logic c, logic [2:0] f);
    op = o; a = x; b = y; comp = c; f3 = f;
  endtask

  // Counts stall cycles from the current cycle until stall drops, then captures the result.
  task automatic count_until_done(output int n, output logic [31:0] r, output logic ok);
    n = 0; r = '0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin
        r  = res;
        ok = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
    end
  endtask

  task automatic run_shift(string name, logic [3:0] o, logic [31:0] x, logic [31:0] y,
                           int exp_n, logic [31:0] exp_r);
    int          n;
    logic [31:0] r;
    logic        ok;
    @(posedge clk); #1;
    drive(o, x, y, 1'b0, F3_BEQ);
    count_until_done(n, r, ok);
    check({name, "_done_in_budget"}, 32'(ok), 32'd1);
    check({name, "_stall_cycles"}, n, exp_n);
    check({name, "_result"}, r, exp_r);
  endtask

  initial begin
    int          n;
    logic [31:0] r;
    logic        ok;
    logic [2:0]  f3s [6];
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rc;
    logic [2:0]  rf;

    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    drive(OP_ADD, 32'd5, 32'd7, 1'b1, F3_BNE);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_result", res, 32'd0);
    check("reset_taken", 32'(taken), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{OP_ADD,  32'd5,         32'd7,         1'b0, F3_BEQ,  32'd12,        1'b0, "add_5_7"});
    vecs.push_back('{OP_SUB,  32'd0,         32'd1,         1'b0, F3_BEQ,  32'hFFFFFFFF,  1'b0, "sub_0_1"});
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF,  32'd1,         1'b0, F3_BEQ,  32'd0,         1'b0, "add_wrap"});
    vecs.push_back('{OP_AND,  32'hF0F0F0F0,  32'hFF00FF00,  1'b0, F3_BEQ,  32'hF000F000,  1'b0, "and"});
    vecs.push_back('{OP_OR,   32'h0F0F0000,  32'h000000F0,  1'b0, F3_BEQ,  32'h0F0F00F0,  1'b0, "or"});
    vecs.push_back('{OP_XOR,  32'hAAAAAAAA,  32'hFFFF0000,  1'b0, F3_BEQ,  32'h5555AAAA,  1'b0, "xor"});
    vecs.push_back('{OP_SLT,  32'hFFFFFFFF,  32'd1,         1'b0, F3_BEQ,  32'd1,         1'b0, "slt_neg"});
    vecs.push_back('{OP_SLT,  32'd1,         32'hFFFFFFFF,  1'b0, F3_BEQ,  32'd0,         1'b0, "slt_pos"});
    vecs.push_back('{OP_SLTU, 32'hFFFFFFFF,  32'd1,         1'b0, F3_BEQ,  32'd0,         1'b0, "sltu"});
    vecs.push_back('{OP_SLL,  32'h12345678,  32'd0,         1'b0, F3_BEQ,  32'h12345678,  1'b0, "sll_shamt0"});
    vecs.push_back('{OP_SRA,  32'h80000000,  32'h00000020,  1'b0, F3_BEQ,  32'h80000000,  1'b0, "sra_shamt0_hi"});
    vecs.push_back('{OP_ADD,  32'd0,         32'd0,         1'b0, F3_BEQ,  32'd0,         1'b0, "bubble"});
    vecs.push_back('{OP_SUB,  32'hFFFFFFFF,  32'd1,         1'b1, F3_BLT,  32'hFFFFFFFE,  1'b1, "blt"});
    vecs.push_back('{OP_SUB,  32'hFFFFFFFF,  32'd1,         1'b1, F3_BLTU, 32'hFFFFFFFE,  1'b0, "bltu"});
    vecs.push_back('{OP_SUB,  32'd5,         32'd5,         1'b1, F3_BEQ,  32'd0,         1'b1, "beq"});
    vecs.push_back('{OP_SUB,  32'd5,         32'd5,         1'b0, F3_BEQ,  32'd0,         1'b0, "beq_nocomp"});
    vecs.push_back('{OP_ADD,  32'd5,         32'd6,         1'b1, F3_BNE,  32'd11,        1'b1, "bne"});
    vecs.push_back('{OP_AND,  32'hFFFFFFFF,  32'd1,         1'b1, F3_BGE,  32'd1,         1'b0, "bge"});
    vecs.push_back('{OP_OR,   32'hFFFFFFFF,  32'd1,         1'b1, F3_BGEU, 32'hFFFFFFFF,  1'b1, "bgeu"});

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].f3);
      @(negedge clk);
      check({vecs[i].name, "_result"}, res, vecs[i].res);
      check({vecs[i].name, "_taken"}, 32'(taken), 32'(vecs[i].tk));
      check({vecs[i].name, "_stall"}, 32'(stall), 32'd0);
    end

    run_shift("sll_1_4",   OP_SLL, 32'd1,        32'd4,  4,  32'h10);
    run_shift("sll_b2b",   OP_SLL, 32'd3,        32'd3,  3,  32'h18);
    run_shift("sra_31",    OP_SRA, 32'h80000000, 32'd31, 31, 32'hFFFFFFFF);
    run_shift("srl_31",    OP_SRL, 32'h80000000, 32'd31, 31, 32'h1);
    run_shift("sll_1",     OP_SLL, 32'd5,        32'd1,  1,  32'hA);

    run_shift("hold_pre",  OP_SLL, 32'd3,        32'd2,  2,  32'hC);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_result_stable", res, 32'hC);
      check("hold_no_stall", 32'(stall), 32'd0);
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold_release_leaves_done", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    check("flush_forces_stall_low", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(OP_ADD, 32'd0, 32'd0, 1'b0, F3_BEQ);
    @(negedge clk);
    check("post_flush_bubble_result", res, 32'd0);
    check("post_flush_bubble_stall", 32'(stall), 32'd0);

    @(posedge clk); #1;
    drive(OP_SLL, 32'd1, 32'd10, 1'b0, F3_BEQ);
    @(negedge clk);
    check("flush_sll_first_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_2nd_cycle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    count_until_done(n, r, ok);
    check("flush_restart_in_budget", 32'(ok), 32'd1);
    check("flush_restart_fresh_count", n, 10);
    check("flush_restart_result", r, 32'h400);

    @(posedge clk); #1;
    drive(OP_SLL, 32'd1, 32'd20, 1'b0, F3_BEQ);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_shift_stall", 32'(stall), 32'd0);
    check("rst_mid_shift_result", res, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_until_done(n, r, ok);
    check("rst_restart_in_budget", 32'(ok), 32'd1);
    check("rst_restart_fresh_count", n, 20);
    check("rst_restart_result", r, 32'h100000);

    for (int it = 0; it < 150; it++) begin
      ro = 4'($urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rf = f3s[$urandom_range(0, 5)];
      if (is_shift_op(ro) && (rb % 32 != 0)) begin
        run_shift("rand_shift", ro, ra, rb, int'(rb % 32), ref_alu(ro, ra, rb));
      end else begin
        @(posedge clk); #1;
        drive(ro, ra, rb, rc, rf);
        @(negedge clk);
        check("rand_result", res, ref_alu(ro, ra, rb));
        check("rand_taken", 32'(taken), 32'(ref_br(rc, rf, ra, rb)));
        check("rand_stall", 32'(stall), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
